game_input_conditioner: RTL and testbench
=========================================

# game_input_conditioner

Front-end stage that conditions raw board inputs before they reach the game top. It synchronizes the active-low push-buttons and the slide switches into the `clk` domain and debounces each button. Per button it produces a clean level plus single-cycle press, release and auto-repeat strobes. The game logic consumes these outputs instead of raw `key`/`sw` pins.

## Interface

Parameters
- `w_key`, 2: number of push-buttons.
- `w_sw`, 9: number of slide switches passed through (sw[9] stays the board reset source).
- `debounce_counter_width`, 20: debounce counter width W; a level change must persist 2^W consecutive cycles. Benches use W=2.
- `repeat_counter_width`, 24: auto-repeat counter width R; repeat period is 2^R cycles. Benches use R=3.

Ports
- `clk` input 1: single clock; all logic in this domain.
- `reset_n` input 1: asynchronous, active-low reset.
- `key_n` input w_key: raw buttons, 0 = pressed, asynchronous.
- `sw` input w_sw: raw switches, asynchronous.
- `key_down` output w_key: debounced level, 1 = held.
- `key_press` output w_key: one-cycle pulse on debounced press.
- `key_release` output w_key: one-cycle pulse on debounced release.
- `key_repeat` output w_key: pulse on press, then every 2^R cycles while held.
- `sw_sync` output w_sw: switches after 2-flop synchronizer.

## Operation

- Synchronizer: two flops per bit. Key flops reset to 1 (released); switch flops reset to 0. The second flop gives `k_sync` (inverted to active-high) and `sw_sync`.
- Debounce, per key, counter `dcnt` [W-1:0], state `key_down`, each clock:
  - `k_sync == key_down`: `dcnt <= 0`.
  - else if `dcnt == 2^W-1`: `key_down <= k_sync`, `dcnt <= 0`.
  - else: `dcnt <= dcnt+1`.
- Any single cycle of agreement resets `dcnt`, so glitches shorter than 2^W cycles are ignored.
- `key_press` / `key_release` are registered and asserted on the same edge that sets or clears `key_down`, for exactly one cycle.
- Repeat, per key, counter `rcnt` [R-1:0]:
  - Cleared while `key_down == 0`.
  - Incremented every cycle while `key_down == 1`, wrapping modulo 2^R.
  - `key_repeat` is registered: it is 1 on the press edge, and on each edge where `key_down` was 1 and `rcnt` was 2^R-1.
- No repeat pulse is issued on or after release.
- Keys are fully independent. Simultaneous press of both keys gives simultaneous pulses.
- Reset (`reset_n` low, any time, including mid-debounce or mid-repeat):
  - Immediately clears `dcnt`, `rcnt`, `key_down`, `key_press`, `key_release`, `key_repeat`, `sw_sync` to 0.
  - Sets the key sync flops to released.
- After reset deasserts with a key physically held, the key is reported as a fresh press only after the full debounce interval.
- No pulses are emitted spuriously at reset release.

## Timing

- Let edge k be the first rising edge that samples the new `key_n` level.
- `k_sync` reflects it after edge k+1. `key_down`, `key_press` or `key_release` update at edge k+1+2^W (k+5 for W=2), provided the level holds throughout.
- Repeat pulses land at press edge P, then P+2^R, P+2·2^R, ... (P+8, P+16 for R=3).
- `sw_sync` latency is 2 edges, with no debounce.
- All outputs are registered. No combinational path from any input to any output.

## Test plan

- Reset: `reset_n`=0 with `key_n`=2'b00 held. All outputs are 0. Release reset and keep keys held: `key_down`=2'b11 and `key_press`=2'b11 pulse exactly once, at edge 1+4 after the first sampling edge (W=2). No pulse before that.
- Clean press/release, key[0] (W=2):
  - Drive low at edge k: `key_down[0]` rises and `key_press[0]`=1 for one cycle at k+5.
  - Drive high at edge m: `key_release[0]` pulses at m+5.
  - key[1] outputs stay 0 throughout.
- Glitch rejection: low pulse on key[1] lasting 3 cycles, then a bounce pattern 1-0-1-0 of 2 cycles each. `key_down[1]` never changes and no pulses occur. A subsequent 4-cycle stable low does register.
- Auto-repeat (R=3): hold key[0] for 30 cycles after press edge P. `key_repeat[0]` is 1 at P, P+8, P+16, P+24 only. Release: no further repeats; `rcnt` restarts at the next press.
- Reset mid-operation: assert `reset_n`=0 at dcnt=2 and again during a held key at `rcnt`=5. Outputs clear within the same cycle, asynchronously. After deassertion the debounce restarts from 0.
- Switches: toggle `sw`=9'h155 then 9'h0AA. `sw_sync` follows 2 edges later each time. Both keys are pressed on the same cycle: `key_press`=2'b11 in one cycle.

Source files
------------

// File: rtl/game_input_conditioner.sv
// ============================================================================
// game_input_conditioner
// Synchronizes buttons and switches, debounces buttons and produces press,
// release and auto-repeat strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module game_input_conditioner #(
    parameter int w_key                  = 2,
    parameter int w_sw                   = 9,
    parameter int debounce_counter_width = 20,
    parameter int repeat_counter_width   = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [w_key-1:0] key_n,
    input  logic [w_sw-1:0]  sw,
    output logic [w_key-1:0] key_down,
    output logic [w_key-1:0] key_press,
    output logic [w_key-1:0] key_release,
    output logic [w_key-1:0] key_repeat,
    output logic [w_sw-1:0]  sw_sync
);

    localparam int c_w = debounce_counter_width;
    localparam int c_r = repeat_counter_width;

    logic [w_key-1:0] key_meta;
    logic [w_key-1:0] key_sync_n;
    logic [w_sw-1:0]  sw_meta;
    logic [w_key-1:0] k_sync;

    // Key flops park at "released" so a held key is re-debounced after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta   <= '1;
            key_sync_n <= '1;
            sw_meta    <= '0;
            sw_sync    <= '0;
        end else begin
            key_meta   <= key_n;
            key_sync_n <= key_meta;
            sw_meta    <= sw;
            sw_sync    <= sw_meta;
        end
    end

    assign k_sync = ~key_sync_n;

    generate
        for (genvar i = 0; i < w_key; i++) begin : g_key
            logic [c_w-1:0] dcnt;
            logic [c_r-1:0] rcnt;
            logic           down_q;
            logic           press_q;
            logic           release_q;
            logic           repeat_q;
            logic           flip;

            assign flip = (k_sync[i] != down_q) && (dcnt == '1);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dcnt      <= '0;
                    rcnt      <= '0;
                    down_q    <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    repeat_q  <= 1'b0;
                end else begin
                    press_q   <= flip && k_sync[i];
                    release_q <= flip && !k_sync[i];
                    // A wrap that coincides with the release edge must not repeat.
                    repeat_q  <= (flip && k_sync[i]) ||
                                 (down_q && !flip && (rcnt == '1));

                    if (k_sync[i] == down_q) begin
                        dcnt <= '0;
                    end else if (dcnt == '1) begin
                        down_q <= k_sync[i];
                        dcnt   <= '0;
                    end else begin
                        dcnt <= dcnt + c_w'(1);
                    end

                    if (down_q) begin
                        rcnt <= rcnt + c_r'(1);
                    end else begin
                        rcnt <= '0;
                    end
                end
            end

            assign key_down[i]    = down_q;
            assign key_press[i]   = press_q;
            assign key_release[i] = release_q;
            assign key_repeat[i]  = repeat_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_game_input_conditioner.sv
// ============================================================================
// tb_game_input_conditioner
// Scoreboard bench: stimulus queues expected strobe events, a monitor checks them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_game_input_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] key_n;
    logic [8:0] sw;
    logic [1:0] key_down;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] key_repeat;
    logic [8:0] sw_sync;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int       cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] rpt;
        logic [1:0] down;
    } ev_t;

    ev_t sb[$];

    game_input_conditioner #(
        .w_key                  (2),
        .w_sw                   (9),
        .debounce_counter_width (2),
        .repeat_counter_width   (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .sw          (sw),
        .key_down    (key_down),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .sw_sync     (sw_sync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] rp, input logic [1:0] d);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.rpt = rp; e.down = d;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_down"},    {30'd0, key_down},    32'd0);
        chk({name, "_press"},   {30'd0, key_press},   32'd0);
        chk({name, "_release"}, {30'd0, key_release}, 32'd0);
        chk({name, "_repeat"},  {30'd0, key_repeat},  32'd0);
        chk({name, "_sw"},      {23'd0, sw_sync},     32'd0);
    endtask

    // Monitor: every strobe must match the oldest expected event, and no
    // expected event may pass unseen.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: expected strobe at cycle %0d still pending at %0d",
                     sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (reset_n && ((key_press | key_release | key_repeat) != 2'b00)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_event: cycle %0d press %b release %b repeat %b down %b",
                         cyc, key_press, key_release, key_repeat, key_down);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release ||
                    e.rpt !== key_repeat || e.down !== key_down) begin
                    errors++;
                    $display("FAIL event: got cyc %0d p %b r %b rp %b d %b, expected cyc %0d p %b r %b rp %b d %b",
                             cyc, key_press, key_release, key_repeat, key_down,
                             e.cyc, e.press, e.rel, e.rpt, e.down);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int p;
        int t;
        reset_n = 1'b0;
        key_n   = 2'b00;
        sw      = 9'h000;
        repeat (3) tick();
        chk_all_zero("reset");

        // Release reset with both keys held: one press after the debounce interval.
        reset_n = 1'b1;
        p = cyc + 6;
        push_ev(p, 2'b11, 2'b00, 2'b11, 2'b11);
        tick_until(p);
        key_n = 2'b11;
        push_ev(p + 6, 2'b00, 2'b11, 2'b00, 2'b00);
        tick_until(p + 14);

        // Clean press / release on key[0].
        key_n = 2'b10;
        p = cyc + 6;
        push_ev(p, 2'b00 | 2'b01, 2'b00, 2'b01, 2'b01);
        tick_until(p);
        key_n = 2'b11;
        push_ev(p + 6, 2'b00, 2'b01, 2'b00, 2'b00);
        tick_until(p + 14);

        // Glitches on key[1]: 3-cycle low, then 2-cycle bounce; none register.
        key_n = 2'b01;
        repeat (3) tick();
        key_n = 2'b11;
        repeat (2) tick();
        key_n = 2'b01;
        repeat (2) tick();
        key_n = 2'b11;
        repeat (2) tick();
        key_n = 2'b01;
        repeat (2) tick();
        key_n = 2'b11;
        repeat (10) tick();
        chk("glitch_down", {30'd0, key_down}, 32'd0);

        // A 4-cycle stable low does register, and releases 4 sampled cycles later.
        e0 = cyc;
        key_n = 2'b01;
        push_ev(e0 + 6, 2'b10, 2'b00, 2'b10, 2'b10);
        repeat (4) tick();
        key_n = 2'b11;
        push_ev(e0 + 10, 2'b00, 2'b10, 2'b00, 2'b00);
        tick_until(e0 + 18);

        // Auto-repeat on key[0].
        key_n = 2'b10;
        p = cyc + 6;
        push_ev(p,      2'b01, 2'b00, 2'b01, 2'b01);
        push_ev(p + 8,  2'b00, 2'b00, 2'b01, 2'b01);
        push_ev(p + 16, 2'b00, 2'b00, 2'b01, 2'b01);
        push_ev(p + 24, 2'b00, 2'b00, 2'b01, 2'b01);
        push_ev(p + 31, 2'b00, 2'b01, 2'b00, 2'b00);
        tick_until(p + 25);
        key_n = 2'b11;
        tick_until(p + 40);

        // Repeat counter restarts on the next press.
        key_n = 2'b10;
        p = cyc + 6;
        push_ev(p,      2'b01, 2'b00, 2'b01, 2'b01);
        push_ev(p + 8,  2'b00, 2'b00, 2'b01, 2'b01);
        push_ev(p + 10, 2'b00, 2'b01, 2'b00, 2'b00);
        tick_until(p + 4);
        key_n = 2'b11;
        tick_until(p + 18);

        // Reset mid-debounce (dcnt = 2), then re-debounce from scratch.
        e0 = cyc;
        key_n = 2'b10;
        tick_until(e0 + 4);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid_debounce");
        repeat (2) tick();
        reset_n = 1'b1;
        p = cyc + 6;
        push_ev(p, 2'b01, 2'b00, 2'b01, 2'b01);
        tick_until(p + 5);
        chk("held_before_rst", {30'd0, key_down}, 32'd1);

        // Reset while held with rcnt = 5: clears without waiting for an edge.
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid_repeat");
        key_n = 2'b11;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (12) tick();

        // Switch synchronizer latency.
        sw = 9'h155;
        tick();
        chk("sw_edge1_a", {23'd0, sw_sync}, 32'h000);
        tick();
        chk("sw_edge2_a", {23'd0, sw_sync}, 32'h155);
        sw = 9'h0AA;
        tick();
        chk("sw_edge1_b", {23'd0, sw_sync}, 32'h155);
        tick();
        chk("sw_edge2_b", {23'd0, sw_sync}, 32'h0AA);

        // Simultaneous press of both keys.
        key_n = 2'b00;
        p = cyc + 6;
        push_ev(p, 2'b11, 2'b00, 2'b11, 2'b11);
        tick_until(p);
        key_n = 2'b11;
        push_ev(p + 6, 2'b00, 2'b11, 2'b00, 2'b00);
        tick_until(p + 20);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
